// File: rtl/instr_exec_unit_pkg.sv
// instr_exec_unit_pkg: shared types for the execution stage behind instr_register.
// These are the same opcode, operand, address and instruction types instr_register uses.
// This package also adds the result type, the FSM state enum and the register depth.
package instr_exec_unit_pkg;

  localparam int NUM_ENTRIES = 32;
  localparam int RES_W       = 64;
  localparam int OP_W        = 32;

  typedef enum logic [3:0] {
    ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
  } opcode_t;

  typedef logic signed [OP_W-1:0]               operand_t;
  typedef logic [$clog2(NUM_ENTRIES)-1:0]       address_t;
  typedef logic signed [RES_W-1:0]              result_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef enum logic [2:0] {
    IDLE, FETCH, EXEC, OUTPUT, DONE
  } exec_state_t;

endpackage

// File: rtl/instr_exec_unit_if.sv
// instr_exec_unit_if: run control, register read port and result handshake.
// When EXEC_STATS_EN is defined, this interface also carries the statistics counters.
interface instr_exec_unit_if #(
  parameter int RESULT_W = instr_exec_unit_pkg::RES_W
);
  import instr_exec_unit_pkg::*;

  logic                       start;
  address_t                   start_ptr;
  logic [5:0]                 count;
  address_t                   read_pointer;
  instruction_t               instruction_word;
  logic                       res_valid;
  logic                       res_ready;
  logic signed [RESULT_W-1:0] res_data;
  opcode_t                    res_opcode;
  address_t                   res_addr;
  logic                       res_err;
  logic                       busy;
  logic                       done;
`ifdef EXEC_STATS_EN
  logic [31:0]                exec_cnt;
  logic [15:0]                err_cnt;
`endif

  modport master (
    output start, start_ptr, count, instruction_word, res_ready,
    input  read_pointer, res_valid, res_data, res_opcode, res_addr, res_err, busy, done
`ifdef EXEC_STATS_EN
    , input exec_cnt, err_cnt
`endif
  );

  modport slave (
    input  start, start_ptr, count, instruction_word, res_ready,
    output read_pointer, res_valid, res_data, res_opcode, res_addr, res_err, busy, done
`ifdef EXEC_STATS_EN
    , output exec_cnt, err_cnt
`endif
  );

endinterface

// File: rtl/instr_exec_unit_exec_alu.sv
// exec_alu: purely combinational opcode evaluation on sign-extended operands.
// This unit flags division or modulo by zero, and any opcode outside the defined set, through err.
module exec_alu #(
  parameter int RESULT_W = instr_exec_unit_pkg::RES_W
) (
  input  instr_exec_unit_pkg::instruction_t iw,
  output logic signed [RESULT_W-1:0]        res,
  output logic                              err
);
  import instr_exec_unit_pkg::*;

  localparam int EXT_W = RESULT_W - OP_W;

  logic signed [RESULT_W-1:0] a, b;

  // Widen operands first so MULT keeps the full product.
  // X or unknown opcodes fall through to the default case and are flagged.
  always_comb begin
    a   = {{EXT_W{iw.op_a[OP_W-1]}}, iw.op_a};
    b   = {{EXT_W{iw.op_b[OP_W-1]}}, iw.op_b};
    res = '0;
    err = 1'b0;
    case (iw.opc)
      ZERO:  res = '0;
      PASSA: res = a;
      PASSB: res = b;
      ADD:   res = a + b;
      SUB:   res = a - b;
      MULT:  res = a * b;
      DIV:   if (b == '0) err = 1'b1; else res = a / b;
      MOD:   if (b == '0) err = 1'b1; else res = a % b;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_exec_unit.sv
// instr_exec_unit: this unit walks read_pointer through instr_register for `count` entries.
// For each entry it takes three cycles: fetch, execute, then output. Each result is offered on a valid/ready handshake.
// Optional feature macro: EXEC_STATS_EN adds saturating exec_cnt/err_cnt counters.
module instr_exec_unit #(
  parameter int RESULT_W    = instr_exec_unit_pkg::RES_W,
  parameter int NUM_ENTRIES = instr_exec_unit_pkg::NUM_ENTRIES
) (
  input logic              clk,
  input logic              reset_n,
  instr_exec_unit_if.slave bus
);
  import instr_exec_unit_pkg::*;

  localparam address_t LAST_ADDR = address_t'(NUM_ENTRIES - 1);

  exec_state_t                state;
  address_t                   rp, addr_q, res_addr_q;
  instruction_t               iw_q;
  logic [5:0]                 remaining;
  logic                       res_valid_q, res_err_q, busy_q, done_q;
  logic signed [RESULT_W-1:0] res_data_q, alu_res;
  opcode_t                    res_opcode_q;
  logic                       alu_err;
  logic                       accept;

  exec_alu #(.RESULT_W(RESULT_W)) u_alu (
    .iw  (iw_q),
    .res (alu_res),
    .err (alu_err)
  );

  assign accept = (state == OUTPUT) && bus.res_ready;

  // Run sequencer. All outputs are registered here, and done and busy change on the transition into DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      rp           <= '0;
      addr_q       <= '0;
      iw_q         <= '0;
      remaining    <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_opcode_q <= ZERO;
      res_addr_q   <= '0;
      res_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          if (bus.count != '0) begin
            rp        <= bus.start_ptr;
            remaining <= bus.count;
            busy_q    <= 1'b1;
            state     <= FETCH;
          end else begin
            done_q    <= 1'b1;
            state     <= DONE;
          end
        end
        FETCH: begin
          iw_q   <= bus.instruction_word;
          addr_q <= rp;
          state  <= EXEC;
        end
        EXEC: begin
          res_data_q   <= alu_res;
          res_err_q    <= alu_err;
          res_opcode_q <= iw_q.opc;
          res_addr_q   <= addr_q;
          res_valid_q  <= 1'b1;
          state        <= OUTPUT;
        end
        OUTPUT: if (bus.res_ready) begin
          res_valid_q <= 1'b0;
          remaining   <= remaining - 6'd1;
          if (remaining == 6'd1) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            rp    <= (rp == LAST_ADDR) ? '0 : rp + address_t'(1);
            state <= FETCH;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EXEC_STATS_EN
  logic [31:0] exec_cnt_q;
  logic [15:0] err_cnt_q;

  // Count accepted results. These counters survive across runs and saturate instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exec_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else if (accept) begin
      if (exec_cnt_q != '1)             exec_cnt_q <= exec_cnt_q + 32'd1;
      if (res_err_q && err_cnt_q != '1) err_cnt_q  <= err_cnt_q + 16'd1;
    end
  end

  assign bus.exec_cnt = exec_cnt_q;
  assign bus.err_cnt  = err_cnt_q;
`endif

  assign bus.read_pointer = rp;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_data     = res_data_q;
  assign bus.res_opcode   = res_opcode_q;
  assign bus.res_addr     = res_addr_q;
  assign bus.res_err      = res_err_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule
